// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// the default 48 MHz hold-off length and a counter-width helper.
package pll_seq_pkg;

    // 100 us of stable lock at 48 MHz before the system reset is released.
    localparam int HOLDOFF_CYCLES_48MHZ = 4800;

    // Default depth of the lock-flag synchroniser.
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLDOFF   = 2'd1,
        RUN       = 2'd2
    } pll_state_t;

    // Width needed for a counter that holds values 0..n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// The slave modport is the sequencer side; the master modport is the
// side that supplies the lock flag and software requests and consumes
// the reset outputs.
interface pll_reset_sequencer_if #(
    parameter int LOSS_CNT_W = 8
);
    import pll_seq_pkg::*;

    // Signalling contract: locked is a level from the PLL, asynchronous to
    // global_clock, and may change at any time. soft_reset_req is a
    // synchronous one-cycle pulse with no acknowledge; it takes effect only
    // when sampled high in RUN with lock held, and is dropped otherwise.
    // sys_reset/ready are complementary registered levels, lost_pulse is a
    // registered one-cycle strobe per lock-loss event, loss_count is a
    // registered saturating count, and dbg_state mirrors the FSM register.
    logic                  locked;
    logic                  soft_reset_req;
    logic                  sys_reset;
    logic                  ready;
    logic                  lost_pulse;
    logic [LOSS_CNT_W-1:0] loss_count;
    pll_state_t            dbg_state;

    modport master (
        output locked,
        output soft_reset_req,
        input  sys_reset,
        input  ready,
        input  lost_pulse,
        input  loss_count,
        input  dbg_state
    );

    modport slave (
        input  locked,
        input  soft_reset_req,
        output sys_reset,
        output ready,
        output lost_pulse,
        output loss_count,
        output dbg_state
    );

endinterface

// File: rtl/sync_ff_chain.sv
// N-stage flop chain bringing an asynchronous flag into the clk domain.
// All stages clear synchronously so a reset also forgets any stale level.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    // Shift the raw flag through the chain; clear drops every stage.
    always_ff @(posedge clk) begin
        if (clr) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: synchronises the PLL lock flag, holds the system in
// reset until lock has persisted for HOLDOFF_CYCLES, then releases it.
// Lock loss in RUN re-asserts reset, pulses lost_pulse and bumps a
// saturating loss counter. A soft request re-runs the hold-off in place.
// Optional build macro PLL_LOCK_GLITCH_FILTER_EN: require FILTER_CYCLES
// consecutive low lock samples in RUN before a loss is declared.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_48MHZ,
    parameter int SYNC_STAGES    = SYNC_STAGES_DEFAULT,
    parameter int LOSS_CNT_W     = 8,
    parameter int FILTER_CYCLES  = 4
) (
    input  logic                  global_clock,
    input  logic                  reset,
    pll_reset_sequencer_if.slave  bus
);

    localparam int CW = cnt_width(HOLDOFF_CYCLES);

    // Refuse to elaborate with settings the sequencer cannot honour.
    if (HOLDOFF_CYCLES < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 ||
        LOSS_CNT_W < 1) begin : g_param_check
        $error("pll_reset_sequencer: illegal parameter value");
    end

    logic                  lock_s;
    pll_state_t            state_q;
    pll_state_t            state_nxt;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_nxt;
    logic                  loss_det;
    logic                  loss_evt;
    logic                  sys_reset_q;
    logic                  ready_q;
    logic                  lost_pulse_q;
    logic [LOSS_CNT_W-1:0] loss_count_q;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (global_clock),
        .clr (reset),
        .d   (bus.locked),
        .q   (lock_s)
    );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int FW = cnt_width(FILTER_CYCLES);

    logic [FW-1:0] filt_q;

    // Count consecutive low lock samples in RUN; any high sample or any
    // state change starts the count over.
    always_ff @(posedge global_clock) begin
        if (reset || lock_s || (state_nxt != state_q)) begin
            filt_q <= '0;
        end else if (state_q == RUN) begin
            filt_q <= filt_q + 1'b1;
        end
    end

    assign loss_det = (state_q == RUN) && !lock_s &&
                      (filt_q == FW'(FILTER_CYCLES - 1));
`else
    assign loss_det = (state_q == RUN) && !lock_s;
`endif

    // Next-state and hold-off counter; a loss beats a soft request.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        loss_evt  = 1'b0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = HOLDOFF;
                    cnt_nxt   = '0;
                end
            end
            HOLDOFF: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == CW'(HOLDOFF_CYCLES - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (loss_det) begin
                    state_nxt = WAIT_LOCK;
                    loss_evt  = 1'b1;
                end else if (bus.soft_reset_req && lock_s) begin
                    state_nxt = HOLDOFF;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and outputs; outputs follow next-state so they move
    // on the same edge as the state register.
    always_ff @(posedge global_clock) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            lost_pulse_q <= 1'b0;
            loss_count_q <= '0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            sys_reset_q  <= (state_nxt != RUN);
            ready_q      <= (state_nxt == RUN);
            lost_pulse_q <= loss_evt;
            if (loss_evt && (loss_count_q != {LOSS_CNT_W{1'b1}})) begin
                loss_count_q <= loss_count_q + 1'b1;
            end
        end
    end

    assign bus.sys_reset  = sys_reset_q;
    assign bus.ready      = ready_q;
    assign bus.lost_pulse = lost_pulse_q;
    assign bus.loss_count = loss_count_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with HOLDOFF_CYCLES=8,
// SYNC_STAGES=2, LOSS_CNT_W=2. Latencies are counted in edges with the
// first edge that samples the new locked level numbered 1, so release is
// seen after edge SYNC+HOLD+1 = 11 and loss after edge SYNC+1 = 3
// (SYNC+FILTER = 6 when PLL_LOCK_GLITCH_FILTER_EN is defined).
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int HOLD = 8;
    localparam int SYNC = 2;
    localparam int LW   = 2;
    localparam int FILT = 4;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int LOSS_STEPS = SYNC + FILT;
`else
    localparam int LOSS_STEPS = SYNC + 1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    // Clock and interface
    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.LOSS_CNT_W(LW)) bus ();

    pll_reset_sequencer #(
        .HOLDOFF_CYCLES (HOLD),
        .SYNC_STAGES    (SYNC),
        .LOSS_CNT_W     (LW),
        .FILTER_CYCLES  (FILT)
    ) dut (
        .global_clock (clk),
        .reset        (reset),
        .bus          (bus.slave)
    );

    // Advance one rising edge, then settle on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sys_reset"}, 32'(bus.sys_reset), 32'd1);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd0);
        chk({tag, "_lost_pulse"}, 32'(bus.lost_pulse), 32'd0);
        chk({tag, "_loss_count"}, 32'(bus.loss_count), 32'd0);
        chk({tag, "_state"}, 32'(bus.dbg_state), 32'(WAIT_LOCK));
    endtask

    // Raise locked from WAIT_LOCK; release expected on edge SYNC+HOLD+1.
    task automatic acquire(input string tag);
        bus.locked = 1'b1;
        repeat (SYNC + HOLD) step();
        chk({tag, "_held"}, 32'(bus.sys_reset), 32'd1);
        chk({tag, "_not_ready"}, 32'(bus.ready), 32'd0);
        step();
        chk({tag, "_released"}, 32'(bus.sys_reset), 32'd0);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_no_pulse"}, 32'(bus.lost_pulse), 32'd0);
        chk({tag, "_run"}, 32'(bus.dbg_state), 32'(RUN));
    endtask

    // Drop locked in RUN; reset expected back on edge LOSS_STEPS.
    task automatic lose(input string tag, input logic [LW-1:0] exp_cnt);
        bus.locked = 1'b0;
        repeat (LOSS_STEPS - 1) step();
        chk({tag, "_still_run"}, 32'(bus.sys_reset), 32'd0);
        step();
        chk({tag, "_asserted"}, 32'(bus.sys_reset), 32'd1);
        chk({tag, "_ready_low"}, 32'(bus.ready), 32'd0);
        chk({tag, "_pulse"}, 32'(bus.lost_pulse), 32'd1);
        chk({tag, "_count"}, 32'(bus.loss_count), 32'(exp_cnt));
        step();
        chk({tag, "_pulse_end"}, 32'(bus.lost_pulse), 32'd0);
    endtask

    // Directed sequence
    initial begin
        reset              = 1'b1;
        bus.locked         = 1'b0;
        bus.soft_reset_req = 1'b0;
        repeat (3) step();
        chk_reset_vals("por");
        reset = 1'b0;

        // No lock: reset held indefinitely.
        repeat (20) step();
        chk("nolock_sys_reset", 32'(bus.sys_reset), 32'd1);
        chk("nolock_ready", 32'(bus.ready), 32'd0);
        chk("nolock_count", 32'(bus.loss_count), 32'd0);

        acquire("acq1");
        lose("loss1", 2'd1);
        acquire("relock");

        // Soft request in RUN: exactly HOLD cycles of reset, no count.
        bus.soft_reset_req = 1'b1;
        step();
        bus.soft_reset_req = 1'b0;
        chk("soft_asserted", 32'(bus.sys_reset), 32'd1);
        chk("soft_state", 32'(bus.dbg_state), 32'(HOLDOFF));
        repeat (HOLD - 1) step();
        chk("soft_last_held", 32'(bus.sys_reset), 32'd1);
        step();
        chk("soft_released", 32'(bus.sys_reset), 32'd0);
        chk("soft_ready", 32'(bus.ready), 32'd1);
        chk("soft_count", 32'(bus.loss_count), 32'd1);

        // Soft request on the same edge the loss is decided: loss wins.
        bus.locked = 1'b0;
        repeat (LOSS_STEPS - 1) step();
        bus.soft_reset_req = 1'b1;
        step();
        bus.soft_reset_req = 1'b0;
        chk("tie_sys_reset", 32'(bus.sys_reset), 32'd1);
        chk("tie_pulse", 32'(bus.lost_pulse), 32'd1);
        chk("tie_count", 32'(bus.loss_count), 32'd2);
        chk("tie_state", 32'(bus.dbg_state), 32'(WAIT_LOCK));
        step();
        chk("tie_pulse_end", 32'(bus.lost_pulse), 32'd0);

        // Hold-off abort: 5 cycles of lock is not enough.
        bus.locked = 1'b1;
        repeat (5) step();
        chk("abort_in_holdoff", 32'(bus.dbg_state), 32'(HOLDOFF));
        bus.locked = 1'b0;
        repeat (15) step();
        chk("abort_sys_reset", 32'(bus.sys_reset), 32'd1);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_pulse", 32'(bus.lost_pulse), 32'd0);
        chk("abort_count", 32'(bus.loss_count), 32'd2);
        chk("abort_state", 32'(bus.dbg_state), 32'(WAIT_LOCK));

`ifdef PLL_LOCK_GLITCH_FILTER_EN
        // A 3-cycle glitch is filtered out, a 4-cycle low is a loss.
        acquire("acq_glitch");
        bus.locked = 1'b0;
        repeat (3) step();
        bus.locked = 1'b1;
        repeat (10) step();
        chk("glitch_sys_reset", 32'(bus.sys_reset), 32'd0);
        chk("glitch_count", 32'(bus.loss_count), 32'd2);
        chk("glitch_state", 32'(bus.dbg_state), 32'(RUN));
        lose("loss_filt", 2'd3);
`else
        acquire("acq3");
        lose("loss3", 2'd3);
`endif

        // Fourth and fifth losses saturate the 2-bit counter at 3.
        acquire("acq4");
        lose("loss4", 2'd3);
        acquire("acq5");
        lose("loss5", 2'd3);

        // Reset while running returns everything to reset values.
        acquire("acq_rst");
        reset = 1'b1;
        step();
        chk_reset_vals("mid_reset");
        reset = 1'b0;
        acquire("after_rst");
        chk("after_rst_count", 32'(bus.loss_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
